// File: rtl/sigencode_z_pkg.sv
// sigencode_z_pkg: shared constants and types for the signature-z encoder.
//   MLDSA_Q        - modulus q
//   GAMMA1_17/19   - the two legal gamma1 values
//   OUT_W          - per-lane output field width (widest gamma1 plus one bit)
//   gamma_sel_e    - per-beat gamma1 selector
//   gamma1_of()    - maps a selector to its gamma1 value
package sigencode_z_pkg;

    localparam int unsigned MLDSA_Q   = 8380417;
    localparam int unsigned GAMMA1_17 = 1 << 17;
    localparam int unsigned GAMMA1_19 = 1 << 19;
    localparam int unsigned OUT_W     = 20;

    typedef enum logic {
        G17 = 1'b0,
        G19 = 1'b1
    } gamma_sel_e;

    function automatic int unsigned gamma1_of(gamma_sel_e sel);
        return (sel == G19) ? GAMMA1_19 : GAMMA1_17;
    endfunction

endpackage

// File: rtl/sigencode_z_pipe_if.sv
// sigencode_z_pipe_if: beat-level handshake bundle of the signature-z encoder.
//   in_valid_i / in_ready_o   - input beat handshake
//   gamma_sel_i               - 0: gamma1 = 2^17, 1: gamma1 = 2^19
//   data_i                    - NUM_LANES packed REG_SIZE-bit coefficients
//   out_valid_o / out_ready_i - output beat handshake
//   data_o                    - NUM_LANES packed OUT_W-bit results
//   lane_err_o                - per-lane range error of the output beat
//   err_sticky_o              - accumulated error since reset or zeroize
// The master modport is the side that feeds inputs and consumes outputs; the
// slave modport is the encoder.
interface sigencode_z_pipe_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned REG_SIZE  = 24,
    parameter int unsigned OUT_W     = 20
);
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic                          gamma_sel_i;
    logic [NUM_LANES*REG_SIZE-1:0] data_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [NUM_LANES*OUT_W-1:0]    data_o;
    logic [NUM_LANES-1:0]          lane_err_o;
    logic                          err_sticky_o;

    modport master (
        output in_valid_i, gamma_sel_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, lane_err_o, err_sticky_o
    );

    modport slave (
        input  in_valid_i, gamma_sel_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, lane_err_o, err_sticky_o
    );
endinterface

// File: rtl/abr_adder.sv
// abr_adder: plain WIDTH-bit adder with carry-in, result taken modulo 2^WIDTH.
//   a_i, b_i  - operands
//   cin_i     - carry in
//   sum_o     - a_i + b_i + cin_i, truncated to WIDTH bits
module abr_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o
);
    assign sum_o = a_i + b_i + WIDTH'(cin_i);
endmodule

// File: rtl/sigencode_z_lane.sv
// sigencode_z_lane: one coefficient lane of the signature-z encoder.
// Stage 1 registers r0 = g - c (REG_SIZE+1 bits, two's complement) and its
// borrow; stage 2 registers out = borrow ? r0 + q : r0 (FIELD_W bits) and the
// range error. Stage enables come from the parent's valid/ready control.
//   clk, reset_n, zeroize - clock, async active-low reset, sync clear
//   s1_load_i / s2_load_i - load enables of stage 1 / stage 2
//   gamma_i               - gamma1 selector of the beat entering stage 1
//   s1_gamma_i            - gamma1 selector of the beat held in stage 1
//   coeff_i               - input coefficient c
//   data_o / err_o        - stage-2 result and range error
module sigencode_z_lane
    import sigencode_z_pkg::*;
#(
    parameter int unsigned REG_SIZE = 24,
    parameter int unsigned MOD_Q    = 8380417,
    parameter int unsigned FIELD_W  = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                s1_load_i,
    input  logic                s2_load_i,
    input  gamma_sel_e          gamma_i,
    input  gamma_sel_e          s1_gamma_i,
    input  logic [REG_SIZE-1:0] coeff_i,
    output logic [FIELD_W-1:0]  data_o,
    output logic                err_o
);
    localparam int unsigned W = REG_SIZE + 1;

    logic [W-1:0]       g_in, c_inv, r0_d, r0_q;
    logic               borrow_q;
    logic [W-1:0]       g_s1, thr_lo, thr_hi;
    logic [FIELD_W-1:0] corr, sum_fix, data_q;
    logic               err_d, err_q;

    always_comb begin
        g_in  = W'(gamma1_of(gamma_i));
        c_inv = ~{1'b0, coeff_i};
    end

    // g + ~c + 1 = g - c
    abr_adder #(.WIDTH(W)) u_sub (
        .a_i   (g_in),
        .b_i   (c_inv),
        .cin_i (1'b1),
        .sum_o (r0_d)
    );

    // c < 2^REG_SIZE and g <= 2^19, so g - c never overflows W bits and the
    // sign bit is exactly (c > g).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_q     <= '0;
            borrow_q <= 1'b0;
        end else if (zeroize) begin
            r0_q     <= '0;
            borrow_q <= 1'b0;
        end else if (s1_load_i) begin
            r0_q     <= r0_d;
            borrow_q <= r0_d[W-1];
        end
    end

    // The error compare is done on r0 rather than c: with c = g - r0,
    // c >= q  <=>  r0 <= g - q   and   c <= q - g  <=>  r0 >= 2g - q.
    always_comb begin
        g_s1   = W'(gamma1_of(s1_gamma_i));
        thr_lo = g_s1 - W'(MOD_Q);
        thr_hi = (g_s1 << 1) - W'(MOD_Q);
        corr   = borrow_q ? FIELD_W'(MOD_Q) : '0;
        err_d  = ($signed(r0_q) <= $signed(thr_lo)) ||
                 (borrow_q && ($signed(r0_q) >= $signed(thr_hi)));
    end

    // Only the low FIELD_W bits of r0 + q survive, so add at that width.
    abr_adder #(.WIDTH(FIELD_W)) u_fix (
        .a_i   (r0_q[FIELD_W-1:0]),
        .b_i   (corr),
        .cin_i (1'b0),
        .sum_o (sum_fix)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (zeroize) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (s2_load_i) begin
            data_q <= sum_fix;
            err_q  <= err_d;
        end
    end

    assign data_o = data_q;
    assign err_o  = err_q;
endmodule

// File: rtl/sigencode_z_pipe.sv
// sigencode_z_pipe: multi-lane, two-stage signature-z encoder (gamma1 - z mod q).
//   clk     - clock
//   reset_n - asynchronous active-low reset
//   zeroize - synchronous clear of all state, highest priority
//   bus     - slave side of sigencode_z_pipe_if (input beat, output beat,
//             per-lane errors, sticky error)
// Owns the valid/ready control, the stage-1 gamma1 selector and the sticky
// error; the per-lane datapath lives in sigencode_z_lane.
module sigencode_z_pipe #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned REG_SIZE  = 24,
    parameter int unsigned MLDSA_Q   = sigencode_z_pkg::MLDSA_Q,
    parameter int unsigned OUT_W     = sigencode_z_pkg::OUT_W
) (
    input logic               clk,
    input logic               reset_n,
    input logic               zeroize,
    sigencode_z_pipe_if.slave bus
);
    import sigencode_z_pkg::*;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_en, s2_en, accept, s2_load;
    logic sticky_q, sticky_d;

    gamma_sel_e in_gamma, s1_gamma_q, s1_gamma_d;

    logic [NUM_LANES-1:0]       lane_err;
    logic [NUM_LANES*OUT_W-1:0] data_all;

    always_comb begin
        in_gamma   = gamma_sel_e'(bus.gamma_sel_i);
        s2_en      = !s2_valid_q || bus.out_ready_i;
        s1_en      = !s1_valid_q || s2_en;
        accept     = bus.in_valid_i && s1_en;
        s2_load    = s1_valid_q && s2_en;
        s1_valid_d = s1_en ? bus.in_valid_i : s1_valid_q;
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        s1_gamma_d = accept ? in_gamma : s1_gamma_q;
        sticky_d   = sticky_q | (s2_valid_q && bus.out_ready_i && (|lane_err));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_gamma_q <= G17;
            sticky_q   <= 1'b0;
        end else if (zeroize) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_gamma_q <= G17;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_gamma_q <= s1_gamma_d;
            sticky_q   <= sticky_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        sigencode_z_lane #(
            .REG_SIZE (REG_SIZE),
            .MOD_Q    (MLDSA_Q),
            .FIELD_W  (OUT_W)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .zeroize    (zeroize),
            .s1_load_i  (accept),
            .s2_load_i  (s2_load),
            .gamma_i    (in_gamma),
            .s1_gamma_i (s1_gamma_q),
            .coeff_i    (bus.data_i[k*REG_SIZE +: REG_SIZE]),
            .data_o     (data_all[k*OUT_W +: OUT_W]),
            .err_o      (lane_err[k])
        );
    end

    assign bus.in_ready_o   = s1_en;
    assign bus.out_valid_o  = s2_valid_q;
    assign bus.data_o       = data_all;
    assign bus.lane_err_o   = lane_err;
    assign bus.err_sticky_o = sticky_q;
endmodule

// File: doc/sigencode_z_pipe.md
# sigencode_z_pipe

Multi-lane, pipelined signature-z encoder for the ML-DSA signing datapath. Each cycle it accepts up to NUM_LANES coefficients of z (values mod q) and produces γ1 − z mod q for each lane. γ1 is 2^17 or 2^19, selected per beat. Each lane also reports whether its coefficient lies outside the legal range (−γ1, γ1]. It sits between the z-computation / norm-check stage and the signature byte packer, with valid/ready flow control on both sides.

## Interface
Parameters:
- NUM_LANES, 4, coefficient lanes processed per beat.
- REG_SIZE, 24, input coefficient width; bit 23 must be 0 for legal inputs.
- MLDSA_Q, 8380417, modulus q.
- OUT_W, 20, per-lane output field width (GAMMA1_MAX + 1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- zeroize  in  1  synchronous clear of all state; takes priority over every other input.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- gamma_sel_i  in  1  0: γ1 = 2^17; 1: γ1 = 2^19; sampled with the beat.
- data_i  in  NUM_LANES*REG_SIZE  lane k occupies bits [k*REG_SIZE +: REG_SIZE].
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accept.
- data_o  out  NUM_LANES*OUT_W  lane k occupies bits [k*OUT_W +: OUT_W]; bits above γ1's width are 0.
- lane_err_o  out  NUM_LANES  per-lane range error for the current output beat.
- err_sticky_o  out  1  OR of every lane_err of every beat accepted downstream since reset or zeroize.

## Operation
- Per lane, with input c and g = γ1:
  - Stage 1 computes r0 = g − c as REG_SIZE+1-bit two's complement and records borrow = (c > g).
  - Stage 2 produces out = borrow ? r0 + q : r0, truncated to OUT_W.
- Legal inputs: c ∈ [0, g] ∪ [q−g+1, q−1]. These give out ∈ [0, 2g−1].
- Error: lane_err = (c ≥ q) || (borrow && c ≤ q−g). data_o is still the computed value, truncated.
- gamma_sel travels down the pipeline with its beat. Mixed-mode back-to-back beats are legal.
- err_sticky_o is set when out_valid_o && out_ready_i && |lane_err_o. It is cleared only by reset or zeroize.
- zeroize clears both stage-valid bits, all data/mode/borrow registers and err_sticky_o. Beats in flight are dropped.

## Timing
- Two-stage pipeline; latency 2 cycles from input acceptance to out_valid_o, with no stall.
- Throughput: one beat per cycle while out_ready_i is held high.
- Stage n loads when its valid bit is 0 or stage n+1 accepts this cycle.
- in_ready_o = !s1_valid || (!s2_valid || out_ready_i). This is combinational and has no dependence on in_valid_i.
- data_o and lane_err_o are held stable while out_valid_o && !out_ready_i. No beat is lost or duplicated under any stall pattern.
- Accept and drain in the same cycle is supported at full occupancy.
- Reset values: out_valid_o 0, data_o 0, lane_err_o 0, err_sticky_o 0, in_ready_o 1.
- Reset or zeroize mid-stream: the next cycle shows the reset state; the following input beat is processed normally.

## Structure
- Package sigencode_z_pkg holds:
  - MLDSA_Q;
  - GAMMA1_17 = 2^17 and GAMMA1_19 = 2^19;
  - OUT_W;
  - an enum gamma_sel_e with values G17 and G19.
- Sub-module sigencode_z_lane:
  - one lane's two-stage datapath, built on two abr_adder instances plus the error compare;
  - takes stage enables from the parent and is instantiated NUM_LANES times.
- The parent owns the valid/ready control, the per-stage gamma_sel registers and err_sticky_o.

## Test plan
- γ1 = 2^19, lanes {0, 524288, 8380416, 7856130}, out_ready held high → {524288, 0, 524289, 1048575}; no errors; out_valid_o 2 cycles after accept.
- γ1 = 2^17, lanes {1, 131072, 8380416, 8249346} → {131071, 0, 131073, 262143}; upper 2 bits of every field 0.
- Error cases:
  - γ1 = 2^19, lanes {524289, 8380417, 7856129, 3} → lane_err_o = 4'b0111, lane 3 = 524285;
  - err_sticky_o rises after the handshake and stays high;
  - zeroize clears it.
- Back-pressure:
  - 8 consecutive beats with alternating gamma_sel, out_ready_i toggled pseudo-randomly;
  - scoreboard: all 8 beats arrive in order, correct, with data held stable during stalls;
  - in_ready_o low exactly when both stages are full and out_ready_i is 0.
- Mid-stream clearing:
  - assert reset_n low for 1 cycle with both stages full → out_valid_o 0 immediately, in_ready_o 1;
  - repeat with zeroize → same result on the next edge;
  - the next beat after either has normal 2-cycle latency.
